// File: rtl/count_sequencer_if.sv
// Button/switch inputs and counter-control outputs of the count sequencer.
// The master side drives the buttons and counter value; the slave side is the sequencer.
interface count_sequencer_if #(
    parameter int CNT_W = 7
);
    logic             start_btn;
    logic             stop_btn;
    logic             load_btn;
    logic             clear_btn;
    logic             up_down;
    logic [CNT_W-1:0] count_in;
    logic             cnt_en;
    logic             cnt_up;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_clr;
    logic             tick;
    logic [1:0]       state_o;
    logic             done;

    modport master (
        output start_btn, stop_btn, load_btn, clear_btn, up_down, count_in,
        input  cnt_en, cnt_up, cnt_load, cnt_load_val, cnt_clr, tick, state_o, done
    );

    modport slave (
        input  start_btn, stop_btn, load_btn, clear_btn, up_down, count_in,
        output cnt_en, cnt_up, cnt_load, cnt_load_val, cnt_clr, tick, state_o, done
    );
endinterface

// File: rtl/count_sequencer.sv
// Control sequencer for the 0-99 up/down counter: conditions pushbuttons into
// prioritised one-cycle strobes, generates the count tick and stops at terminal.
module count_sequencer #(
    parameter int TICK_DIV    = 50000000,
    parameter int MAX_COUNT   = 99,
    parameter int UP_PRESET   = 90,
    parameter int DOWN_PRESET = 10,
    parameter int CNT_W       = 7
) (
    input  logic              Clk,
    input  logic              reset,
    count_sequencer_if.slave  bus
);
    localparam int             DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    function automatic logic is_term(input logic up, input logic [CNT_W-1:0] cnt);
        if (up) begin
            return cnt == CNT_W'(MAX_COUNT);
        end
        return cnt == '0;
    endfunction

    function automatic logic [CNT_W-1:0] preset_val(input logic up);
        return up ? CNT_W'(UP_PRESET) : CNT_W'(DOWN_PRESET);
    endfunction

    // Button bit order: {clear, load, stop, start}
    logic [3:0]       sync1_q, sync2_q, sync3_q;
    logic [3:0]       btn_raw;
    logic [3:0]       btn_edge;
    logic             cmd_clr, cmd_load, cmd_stop, cmd_start;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             cnt_up_q, cnt_up_d;
    logic [CNT_W-1:0] load_val_q, load_val_d;
    logic             cnt_en_q, cnt_en_d;
    logic             cnt_load_q, cnt_load_d;
    logic             cnt_clr_q, cnt_clr_d;
    logic             tick_q, tick_d;
    logic             tick_evt;

    assign btn_raw  = {bus.clear_btn, bus.load_btn, bus.stop_btn, bus.start_btn};
    assign btn_edge = sync2_q & ~sync3_q;

    // Only the highest-priority edge of a cycle survives.
    assign cmd_clr   = btn_edge[3];
    assign cmd_load  = btn_edge[2] & ~btn_edge[3];
    assign cmd_stop  = btn_edge[1] & ~|btn_edge[3:2];
    assign cmd_start = btn_edge[0] & ~|btn_edge[3:1];

    assign tick_evt = (state_q == ST_RUN) && (div_q == DIV_LAST);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        cnt_up_d   = cnt_up_q;
        load_val_d = load_val_q;
        cnt_en_d   = 1'b0;
        cnt_load_d = 1'b0;
        cnt_clr_d  = 1'b0;
        tick_d     = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (cmd_start) begin
                    cnt_up_d = bus.up_down;
                    div_d    = '0;
                    state_d  = is_term(bus.up_down, bus.count_in) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (cmd_stop) begin
                    // Divider holds its position so the resumed interval is not restarted.
                    state_d = ST_PAUSE;
                end else if (tick_evt) begin
                    div_d  = '0;
                    tick_d = 1'b1;
                    if (is_term(cnt_up_q, bus.count_in)) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_en_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_PAUSE: begin
                if (cmd_start) begin
                    state_d = ST_RUN;
                end
            end
        endcase

        if (cmd_load && (state_q != ST_RUN)) begin
            cnt_load_d = 1'b1;
            load_val_d = preset_val(bus.up_down);
            cnt_up_d   = bus.up_down;
            div_d      = '0;
            state_d    = ST_IDLE;
        end

        if (cmd_clr) begin
            cnt_clr_d = 1'b1;
            cnt_en_d  = 1'b0;
            tick_d    = 1'b0;
            div_d     = '0;
            state_d   = ST_IDLE;
        end
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync3_q    <= '0;
            state_q    <= ST_IDLE;
            div_q      <= '0;
            cnt_up_q   <= 1'b1;
            load_val_q <= '0;
            cnt_en_q   <= 1'b0;
            cnt_load_q <= 1'b0;
            cnt_clr_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_up_q   <= cnt_up_d;
            load_val_q <= load_val_d;
            cnt_en_q   <= cnt_en_d;
            cnt_load_q <= cnt_load_d;
            cnt_clr_q  <= cnt_clr_d;
            tick_q     <= tick_d;
        end
    end

    assign bus.cnt_en       = cnt_en_q;
    assign bus.cnt_up       = cnt_up_q;
    assign bus.cnt_load     = cnt_load_q;
    assign bus.cnt_load_val = load_val_q;
    assign bus.cnt_clr      = cnt_clr_q;
    assign bus.tick         = tick_q;
    assign bus.state_o      = state_q;
    assign bus.done         = (state_q == ST_DONE);
endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer with TICK_DIV=4 and a model 0-99 counter attached;
// strobes are checked against a queue of expected events by a separate monitor.
`timescale 1ns/1ps
module tb_count_sequencer;
    localparam int CNT_W = 7;
    localparam logic [1:0] K_EN = 2'd0, K_LOAD = 2'd1, K_CLR = 2'd2, K_MULTI = 2'd3;
    localparam logic [3:0] B_START = 4'b0001, B_STOP = 4'b0010, B_LOAD = 4'b0100, B_CLEAR = 4'b1000;

    typedef struct {
        logic [1:0]       kind;
        logic [CNT_W-1:0] val;
    } exp_t;

    logic Clk = 1'b0;
    logic reset = 1'b0;
    logic [CNT_W-1:0] count;
    exp_t expq[$];
    int n_pass = 0;
    int n_total = 0;
    logic [1:0] act_kind;
    logic [CNT_W-1:0] act_val;
    exp_t e;

    count_sequencer_if #(.CNT_W(CNT_W)) bus ();

    count_sequencer #(
        .TICK_DIV(4), .MAX_COUNT(99), .UP_PRESET(90), .DOWN_PRESET(10), .CNT_W(CNT_W)
    ) dut (
        .Clk(Clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    assign bus.count_in = count;

    always @(posedge Clk) begin
        if (!reset)                count <= '0;
        else if (bus.cnt_clr)      count <= '0;
        else if (bus.cnt_load)     count <= bus.cnt_load_val;
        else if (bus.cnt_en)       count <= bus.cnt_up ? count + 7'd1 : count - 7'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    task automatic push_exp(input logic [1:0] kind, input logic [CNT_W-1:0] val);
        exp_t x;
        x.kind = kind;
        x.val  = val;
        expq.push_back(x);
    endtask

    always @(negedge Clk) begin
        if (reset === 1'b1 && (bus.cnt_en || bus.cnt_load || bus.cnt_clr)) begin
            case ({bus.cnt_clr, bus.cnt_load, bus.cnt_en})
                3'b001:  act_kind = K_EN;
                3'b010:  act_kind = K_LOAD;
                3'b100:  act_kind = K_CLR;
                default: act_kind = K_MULTI;
            endcase
            act_val = bus.cnt_load ? bus.cnt_load_val : (bus.cnt_clr ? '0 : count);
            if (expq.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_strobe: got kind %0d val %0d, required no strobe", act_kind, act_val);
            end else begin
                e = expq.pop_front();
                chk("strobe_kind", 32'(act_kind), 32'(e.kind));
                chk("strobe_val", 32'(act_val), 32'(e.val));
            end
        end
    end

    task automatic set_btns(input logic [3:0] m);
        bus.start_btn = m[0];
        bus.stop_btn  = m[1];
        bus.load_btn  = m[2];
        bus.clear_btn = m[3];
    endtask

    task automatic pulse(input logic [3:0] m);
        set_btns(m);
        @(negedge Clk);
        set_btns(4'b0000);
    endtask

    task automatic wait_state(input string name, input logic [1:0] st, input int budget);
        for (int i = 0; i < budget && bus.state_o !== st; i++) @(negedge Clk);
        chk(name, 32'(bus.state_o), 32'(st));
    endtask

    task automatic wait_count(input string name, input logic [CNT_W-1:0] v, input int budget);
        for (int i = 0; i < budget && count !== v; i++) @(negedge Clk);
        chk(name, 32'(count), 32'(v));
    endtask

    initial begin
        set_btns(4'b0000);
        bus.up_down = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_state", 32'(bus.state_o), 32'd0);
        chk("rst_cnt_en", 32'(bus.cnt_en), 32'd0);
        chk("rst_cnt_load", 32'(bus.cnt_load), 32'd0);
        chk("rst_cnt_clr", 32'(bus.cnt_clr), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_cnt_up", 32'(bus.cnt_up), 32'd1);
        chk("rst_load_val", 32'(bus.cnt_load_val), 32'd0);
        reset = 1'b1;

        // Up count 0 -> 99, then hold at terminal
        for (int i = 0; i < 99; i++) push_exp(K_EN, 7'(i));
        pulse(B_START);
        @(negedge Clk);
        chk("start_latency_pre", 32'(bus.state_o), 32'd0);
        @(negedge Clk);
        chk("start_run", 32'(bus.state_o), 32'd1);
        repeat (3) @(negedge Clk);
        chk("en_not_early", 32'(bus.cnt_en), 32'd0);
        @(negedge Clk);
        chk("first_en", 32'(bus.cnt_en), 32'd1);
        chk("first_tick", 32'(bus.tick), 32'd1);
        wait_state("up_done", 2'd3, 600);
        chk("up_done_count", 32'(count), 32'd99);
        chk("up_done_flag", 32'(bus.done), 32'd1);
        repeat (12) @(negedge Clk);
        chk("no_wrap", 32'(count), 32'd99);
        chk("done_holds", 32'(bus.state_o), 32'd3);

        // Load presets, then count down 10 -> 0
        push_exp(K_LOAD, 7'd90);
        pulse(B_LOAD);
        repeat (2) @(negedge Clk);
        chk("load_up_strobe", 32'(bus.cnt_load), 32'd1);
        chk("load_up_val", 32'(bus.cnt_load_val), 32'd90);
        chk("load_to_idle", 32'(bus.state_o), 32'd0);
        @(negedge Clk);
        chk("load_one_cycle", 32'(bus.cnt_load), 32'd0);
        chk("load_up_count", 32'(count), 32'd90);
        bus.up_down = 1'b0;
        push_exp(K_LOAD, 7'd10);
        pulse(B_LOAD);
        repeat (2) @(negedge Clk);
        chk("load_dn_val", 32'(bus.cnt_load_val), 32'd10);
        chk("load_dn_dir", 32'(bus.cnt_up), 32'd0);
        for (int i = 10; i > 0; i--) push_exp(K_EN, 7'(i));
        pulse(B_START);
        wait_state("down_done", 2'd3, 200);
        chk("down_done_count", 32'(count), 32'd0);
        chk("down_done_flag", 32'(bus.done), 32'd1);

        // Stop at count 5 coinciding with a tick, then resume with switch flipped
        push_exp(K_LOAD, 7'd10);
        pulse(B_LOAD);
        repeat (3) @(negedge Clk);
        chk("reload_count", 32'(count), 32'd10);
        for (int i = 10; i > 5; i--) push_exp(K_EN, 7'(i));
        pulse(B_START);
        wait_count("reach5", 7'd5, 100);
        pulse(B_STOP);
        @(negedge Clk);
        @(negedge Clk);
        chk("stop_pause", 32'(bus.state_o), 32'd2);
        chk("stop_suppress_tick", 32'(bus.tick), 32'd0);
        repeat (8) @(negedge Clk);
        chk("pause_frozen", 32'(count), 32'd5);
        bus.up_down = 1'b1;
        push_exp(K_EN, 7'd5);
        pulse(B_START);
        @(negedge Clk);
        @(negedge Clk);
        chk("resume_run", 32'(bus.state_o), 32'd1);
        chk("resume_no_en_yet", 32'(bus.cnt_en), 32'd0);
        @(negedge Clk);
        chk("resume_remaining", 32'(bus.cnt_en), 32'd1);
        chk("resume_dir", 32'(bus.cnt_up), 32'd0);

        // Clear and start together: clear wins
        push_exp(K_CLR, 7'd0);
        pulse(B_CLEAR | B_START);
        @(negedge Clk);
        @(negedge Clk);
        chk("clear_wins_strobe", 32'(bus.cnt_clr), 32'd1);
        chk("clear_wins_state", 32'(bus.state_o), 32'd0);
        @(negedge Clk);
        chk("clear_count", 32'(count), 32'd0);
        chk("start_dropped", 32'(bus.state_o), 32'd0);

        // Load pressed in RUN is ignored
        pulse(B_START);
        @(negedge Clk);
        @(negedge Clk);
        chk("run_again", 32'(bus.state_o), 32'd1);
        push_exp(K_EN, 7'd0);
        pulse(B_LOAD);
        @(negedge Clk);
        @(negedge Clk);
        chk("load_in_run_ignored", 32'(bus.cnt_load), 32'd0);
        chk("load_in_run_state", 32'(bus.state_o), 32'd1);
        @(negedge Clk);
        chk("tick_after_ignored_load", 32'(bus.cnt_en), 32'd1);

        // Held start yields one command: a stop during the hold must stick
        push_exp(K_CLR, 7'd0);
        pulse(B_CLEAR);
        @(negedge Clk);
        @(negedge Clk);
        chk("clear_to_idle", 32'(bus.state_o), 32'd0);
        bus.start_btn = 1'b1;
        repeat (3) @(negedge Clk);
        chk("held_start_run", 32'(bus.state_o), 32'd1);
        bus.stop_btn = 1'b1;
        @(negedge Clk);
        bus.stop_btn = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("held_stop_pause", 32'(bus.state_o), 32'd2);
        repeat (14) @(negedge Clk);
        chk("held_start_single", 32'(bus.state_o), 32'd2);
        bus.start_btn = 1'b0;
        repeat (4) @(negedge Clk);
        chk("release_no_cmd", 32'(bus.state_o), 32'd2);

        // Reset mid-RUN with a clear edge pending in the synchroniser
        bus.up_down = 1'b0;
        push_exp(K_LOAD, 7'd10);
        pulse(B_LOAD);
        repeat (3) @(negedge Clk);
        pulse(B_START);
        @(negedge Clk);
        @(negedge Clk);
        chk("pre_reset_run", 32'(bus.state_o), 32'd1);
        chk("pre_reset_dir", 32'(bus.cnt_up), 32'd0);
        pulse(B_CLEAR);
        @(negedge Clk);
        reset = 1'b0;
        @(negedge Clk);
        chk("midrun_rst_state", 32'(bus.state_o), 32'd0);
        chk("midrun_rst_clr", 32'(bus.cnt_clr), 32'd0);
        chk("midrun_rst_en", 32'(bus.cnt_en), 32'd0);
        chk("midrun_rst_dir", 32'(bus.cnt_up), 32'd1);
        reset = 1'b1;
        @(negedge Clk);
        chk("post_rst_clr", 32'(bus.cnt_clr), 32'd0);
        chk("post_rst_state", 32'(bus.state_o), 32'd0);
        @(negedge Clk);
        chk("post_rst_clr2", 32'(bus.cnt_clr), 32'd0);

        repeat (2) @(negedge Clk);
        chk("scoreboard_empty", 32'(expq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Control block for the 0–99 up/down display counter on the Spartan-6 board.
- Turns raw board pushbuttons (start/stop/load/clear) and the direction switch into single-cycle, prioritised control strobes for the counter.
- Generates the count-rate tick from Clk and stops the count at the terminal value instead of letting it wrap.
- Sits between the button/switch inputs and the counter datapath; reads the counter value back for terminal detection.

Parameters:
- TICK_DIV, 50000000, Clk cycles per count step (1 Hz at 50 MHz); minimum 2.
- MAX_COUNT, 99, terminal value in up mode.
- UP_PRESET, 90, value loaded by load when direction is up.
- DOWN_PRESET, 10, value loaded by load when direction is down.
- CNT_W, 7, counter value width.

Ports:
- Clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- start_btn  in  1  raw pushbutton, asynchronous to Clk.
- stop_btn  in  1  raw pushbutton, asynchronous to Clk.
- load_btn  in  1  raw pushbutton, asynchronous to Clk.
- clear_btn  in  1  raw pushbutton, asynchronous to Clk.
- up_down  in  1  level; 1 = up, 0 = down.
- count_in  in  CNT_W  current counter value.
- cnt_en  out  1  one-cycle step strobe to the counter.
- cnt_up  out  1  latched direction to the counter.
- cnt_load  out  1  one-cycle load strobe.
- cnt_load_val  out  CNT_W  value to load; valid while cnt_load is high.
- cnt_clr  out  1  one-cycle clear-to-0 strobe.
- tick  out  1  divider tick, for debug/LED.
- state_o  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.
- done  out  1  high while in DONE.

Behaviour:
- Reset (reset low at a Clk edge):
  - State IDLE; divider 0; synchroniser flops 0.
  - cnt_en, cnt_load, cnt_clr, tick, done = 0; cnt_load_val = 0; cnt_up = 1.
- Button conditioning:
  - Each *_btn passes through a 2-flop synchroniser, then a rising-edge detector (sync2 & ~sync3).
  - Holding a button produces exactly one command.
  - Response latency is fixed at 3 Clk edges from the first edge that samples the button high to the registered output change.
- Command priority when several edges arrive in the same cycle: clear > load > stop > start. Lower-priority commands in that cycle are dropped.
- Terminal condition (term):
  - Up mode (cnt_up = 1): count_in == MAX_COUNT.
  - Down mode (cnt_up = 0): count_in == 0.
- Divider:
  - Counts 0..TICK_DIV-1 only in RUN; tick pulses for 1 cycle when it reaches TICK_DIV-1, then it returns to 0.
  - Frozen in PAUSE, so a resumed interval continues where it stopped.
  - Cleared to 0 on entry to RUN from IDLE or DONE, on clear, and on load.
- Transitions:
  - IDLE, start: latch cnt_up <= up_down. Go to DONE if term (evaluated with the new direction), else RUN.
  - RUN, tick:
    - term: go to DONE; cnt_en not pulsed.
    - Otherwise: cnt_en = 1 for exactly that cycle.
  - RUN, stop: go to PAUSE; a tick in the same cycle is suppressed.
  - PAUSE, start: go to RUN; direction keeps its latched value and up_down is ignored.
  - DONE, start: behaves as IDLE start (re-latch direction, re-evaluate term).
  - stop in IDLE, PAUSE or DONE: no effect.
  - load in IDLE, PAUSE or DONE:
    - cnt_load = 1 for 1 cycle; cnt_load_val = UP_PRESET if up_down else DOWN_PRESET (live switch value).
    - cnt_up <= up_down; state -> IDLE.
  - load in RUN: ignored.
  - clear in any state: cnt_clr = 1 for 1 cycle; state -> IDLE.
- Direction changes:
  - up_down changes in RUN or PAUSE have no effect until the next start from IDLE/DONE, or a load.
- Strobe exclusivity: cnt_en, cnt_load and cnt_clr are mutually exclusive in every cycle.
- done == (state_o == DONE).
- Reset mid-RUN: the next cycle shows reset values; any pending synchronised button edge is discarded.

Test Plan (TICK_DIV=4, model counter attached):
- Reset low 3 cycles, all buttons 0 -> state_o=00; cnt_en, cnt_load, cnt_clr, done all 0; cnt_up=1.
- up_down=1, count 0, start pulse -> RUN 3 edges later. cnt_en pulses every 4 cycles; count reaches 99 -> DONE with no further cnt_en; count stays 99 (no wrap to 0).
- up_down=1, load -> cnt_load 1 cycle with val 90. up_down=0, load -> val 10. Start in down mode -> count 10..0 -> DONE, done=1.
- RUN at count 5: stop -> PAUSE, count frozen. Flip up_down, then start -> resumes in the original direction; first cnt_en arrives after the remaining divider cycles, not a full 4.
- clear_btn and start_btn rise in the same cycle while RUN -> only cnt_clr pulses; state IDLE; no cnt_en. Load pressed in RUN -> no cnt_load.
- start_btn held high 20 cycles -> exactly one start command. Reset asserted mid-RUN -> IDLE next cycle; no strobe on the following cycle.
